// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path and the instruction ROM.
// The fetchability check lives here so the ROM side can reuse the same bounds rule.
package fetch_pkg;

  localparam int          INSTR_BYTES      = 4;
  localparam int          DEFAULT_MEM_SIZE = 1024;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fetch_entry_t;

  // Widened to 65 bits so a PC near 2^64 cannot wrap and masquerade as in range.
  function automatic logic pc_is_fetchable(input logic [63:0] pc, input logic [64:0] mem_size);
    logic [64:0] last_byte;
    last_byte = {1'b0, pc} + 65'(INSTR_BYTES - 1);
    return (pc[1:0] == 2'b00) && (last_byte < mem_size);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small word/PC queue between fetch and decode, with a flush for redirects.
// The head is read combinationally so a word pushed at one edge is visible right after it.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  entry_t           wdata,
  output entry_t           rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t             r_mem [DEPTH];
  entry_t             r_hold;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_do_pop;
  logic               w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && !flush && (!full || w_do_pop);

  // When empty, present the last entry handed out rather than a stale slot.
  assign rdata = empty ? r_hold : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_do_pop) begin
        r_hold <= r_mem[r_rd_ptr];
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_do_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_do_push, w_do_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch requester: walks the PC through the combinational instruction ROM and queues
// word/PC pairs for decode, with redirect flush and a sticky bounds/alignment fault.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MEM_SIZE = DEFAULT_MEM_SIZE,
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic [63:0]              imem_address,
  input  logic [31:0]              imem_instruction,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [63:0]              out_pc,
  output logic                     fetch_fault,
  output logic [$clog2(DEPTH):0]   occupancy
);

  logic [63:0]   r_pc;
  logic          r_fault;

  logic          w_pc_ok;
  logic          w_pop;
  logic          w_push;
  logic          w_fault_set;
  logic          w_full;
  logic          w_empty;
  fetch_entry_t  w_wdata;
  fetch_entry_t  w_head;

  assign w_pc_ok     = pc_is_fetchable(r_pc, 65'(MEM_SIZE));
  assign w_pop       = out_valid && out_ready;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign w_push      = fetch_en && w_pc_ok && !r_fault && !redirect_valid && (!w_full || w_pop);
  assign w_fault_set = fetch_en && !w_pc_ok && !redirect_valid;

  assign w_wdata = '{instr: imem_instruction, pc: r_pc};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_pc    <= redirect_pc;
      r_fault <= 1'b0;
    end else begin
      if (w_push) begin
        r_pc <= r_pc + 64'(INSTR_BYTES);
      end
      if (w_fault_set) begin
        r_fault <= 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (redirect_valid),
    .wdata   (w_wdata),
    .rdata   (w_head),
    .count   (occupancy),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign imem_address = r_pc;
  assign out_valid    = !w_empty;
  assign out_instr    = w_head.instr;
  assign out_pc       = w_head.pc;
  assign fetch_fault  = r_fault;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue against a 1 KiB ROM whose word i holds 32'hA0 + i.
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] imem_address;
  logic [31:0] imem_instruction;
  logic        fetch_en;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        fetch_fault;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [63:0] addr);
    if (addr < 64'd1024) return 32'hA0 + 32'(addr >> 2);
    return 32'hDEAD_BEEF;
  endfunction

  assign imem_instruction = rom_word(imem_address);

  instr_fetch_queue #(
    .DEPTH    (DEPTH),
    .MEM_SIZE (1024),
    .RESET_PC (64'h0)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .fetch_en         (fetch_en),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .fetch_fault      (fetch_fault),
    .occupancy        (occupancy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;

    #2;
    check("rst_valid", out_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_addr", imem_address, 64'h0);
    check("rst_fault", fetch_fault, 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc", out_pc, 0);

    // Stream with the consumer always ready
    @(negedge clk);
    reset_n   = 1'b1;
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_pc", out_pc, 64'(4 * k));
      check("stream_instr", out_instr, 64'(32'hA0 + k));
      check("stream_occ", occupancy, 1);
    end

    // Back-pressure: fill to DEPTH, pc freezes at 16
    out_ready = 1'b0;
    redirect(64'h0);
    check("bp_flush_occ", occupancy, 0);
    check("bp_flush_addr", imem_address, 64'h0);
    for (int k = 0; k < 10; k++) tick();
    check("bp_full_occ", occupancy, 4);
    check("bp_full_addr", imem_address, 64'd16);
    check("bp_head_pc", out_pc, 64'h0);
    check("bp_head_instr", out_instr, 64'hA0);
    out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      check("bp_drain_pc", out_pc, 64'(4 * j));
      check("bp_drain_instr", out_instr, 64'(32'hA0 + j));
      check("bp_drain_occ", occupancy, 4);
    end

    // Redirect with three entries queued
    out_ready = 1'b0;
    redirect(64'h0);
    for (int k = 0; k < 3; k++) tick();
    check("rd_occ3", occupancy, 3);
    out_ready = 1'b1;
    redirect(64'h40);
    check("rd_flush_occ", occupancy, 0);
    check("rd_flush_valid", out_valid, 0);
    tick();
    check("rd_new_valid", out_valid, 1);
    check("rd_new_pc", out_pc, 64'h40);
    check("rd_new_instr", out_instr, 64'hB0);

    // Out of bounds at the top of the ROM
    out_ready = 1'b0;
    redirect(64'd1016);
    tick();
    check("oob_head_pc", out_pc, 64'd1016);
    check("oob_head_instr", out_instr, 64'h19E);
    tick();
    check("oob_occ2", occupancy, 2);
    check("oob_addr", imem_address, 64'd1024);
    check("oob_nofault_yet", fetch_fault, 0);
    tick();
    check("oob_fault", fetch_fault, 1);
    tick();
    check("oob_nopush_occ", occupancy, 2);
    check("oob_pc_hold", imem_address, 64'd1024);
    out_ready = 1'b1;
    tick();
    check("oob_drain_pc", out_pc, 64'd1020);
    check("oob_drain_instr", out_instr, 64'h19F);
    check("oob_drain_occ", occupancy, 1);
    tick();
    check("oob_empty_valid", out_valid, 0);
    check("oob_fault_sticky", fetch_fault, 1);
    redirect(64'h0);
    check("oob_fault_clr", fetch_fault, 0);
    tick();
    check("oob_resume_valid", out_valid, 1);
    check("oob_resume_pc", out_pc, 64'h0);

    // Misaligned redirect
    redirect(64'h6);
    check("mis_addr", imem_address, 64'h6);
    check("mis_fault_pre", fetch_fault, 0);
    tick();
    check("mis_fault", fetch_fault, 1);
    check("mis_occ", occupancy, 0);
    check("mis_valid", out_valid, 0);

    // Asynchronous reset between edges
    out_ready = 1'b0;
    redirect(64'h0);
    tick();
    tick();
    check("ar_occ2", occupancy, 2);
    check("ar_addr_pre", imem_address, 64'd8);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_occ", occupancy, 0);
    check("ar_addr", imem_address, 64'h0);
    check("ar_fault", fetch_fault, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
